inst_sram_resp: RTL
===================

# inst_sram_resp

Responder for the instruction SRAM port driven by the fetch stage. It accepts one request per cycle on the `inst_sram_*` interface, returns read data one cycle after a request, and holds that data while the fetch stage is stalled. It contains a word-addressed memory array with byte-write support and a backdoor load port used by the bench and boot loader. It also provides read/write statistics and a sticky out-of-range flag.

## Interface
- `ADDR_BASE`, 32'h1c000000, byte address mapped to word 0.
- `DEPTH_LOG2`, 16, log2 of array depth in 32-bit words (default 256 KiB).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous and active-high.
- `inst_sram_en` input 1: request strobe; sampled on the rising edge.
- `inst_sram_we` input 4: byte write enables; 4'h0 means read.
- `inst_sram_addr` input 32: byte address.
- `inst_sram_wdata` input 32: write data, byte lane i = bits [8i+7:8i].
- `inst_sram_rdata` output 32: registered read data.
- `ld_en` input 1: backdoor word write strobe.
- `ld_addr` input DEPTH_LOG2: backdoor word index.
- `ld_data` input 32: backdoor write data.
- `access_err` output 1: sticky; set by any out-of-range request.
- `rd_cnt` output 32: count of accepted reads.
- `wr_cnt` output 32: count of accepted writes.

## Operation
- **Address decode**
  - off = `inst_sram_addr` - ADDR_BASE, computed modulo 2^32.
  - In range iff `inst_sram_addr` >= ADDR_BASE and off < 4·2^DEPTH_LOG2.
  - Word index = off[DEPTH_LOG2+1:2].
  - Bits [1:0] are ignored: misaligned requests act on the containing word. Alignment faults are the fetch stage's job.
- **Read** (en=1, we=0)
  - In range: `inst_sram_rdata` <= mem[idx].
  - Out of range: `inst_sram_rdata` <= 32'h02800000 (NOP) and `access_err` <= 1.
  - `rd_cnt` increments in both cases.
- **Write** (en=1, we≠0)
  - In range: each byte lane i with we[i]=1 is updated from wdata. Other lanes are untouched.
  - Out of range: memory is unchanged and `access_err` <= 1.
  - `inst_sram_rdata` is loaded with the pre-write word (in range) or the NOP (out of range). This gives one-cycle read-modify-write visibility.
  - `wr_cnt` increments in both cases.
- **Idle** (en=0): `inst_sram_rdata` holds its value indefinitely. The fetch stage relies on this while decode back-pressures.
- **Backdoor load**
  - `ld_en`=1 writes `ld_data` to mem[`ld_addr`], full word.
  - If a front-port write hits the same index in the same cycle, the backdoor wins and the front-port write is dropped. `wr_cnt` still increments.
  - A front-port read to the same index returns the old word, or the new word with bypass enabled.
- **Counters**: 32-bit, wrap from 32'hffffffff to 0. There is no saturation.
- **Reset**
  - Affects only registers: `inst_sram_rdata` = 32'h0, `access_err` = 0, `rd_cnt` = 0, `wr_cnt` = 0.
  - The memory array is not reset; its contents survive reset.
  - A request coinciding with reset assertion is discarded.

## Timing
- Read latency is 1: the request is sampled at edge N and `inst_sram_rdata` is valid from just after edge N until the next accepted request.
- Throughput is one request per cycle, with no back-pressure. The responder is always ready; there is no stall output.
- A write commits at edge N. A read of the same word sampled at edge N+1 sees the new data.
- `access_err` and the counters update at the same edge as the request.
- Reset deassertion: the first request is accepted at the first rising edge with `reset`=0.

## Configuration
- `INST_SRAM_BYPASS_EN` defined:
  - A same-cycle collision (front-port request and any write to the same index) returns the post-write merged word on `inst_sram_rdata`.
  - This covers both front-port writes and backdoor loads.
- Not defined: a collision returns the pre-write word, matching plain synchronous-SRAM read-first behaviour.

## Test plan
- **Sequential fetch.** Backdoor-load words 0..3 with 32'h11111111·(i+1). Read 0x1c000000, 0x1c000004, … on consecutive cycles. Required: rdata on successive cycles = 0x11111111, 0x22222222, 0x33333333, 0x44444444; `rd_cnt`=4.
- **Stall hold.** Read 0x1c000008, then drop en for 5 cycles. Required: rdata stays 0x33333333 for all 5 cycles.
- **Byte write.** Write we=4'b0101, wdata=0xaabbccdd to 0x1c000000, then read it. Required: next read returns 0x11bb11dd; `wr_cnt`=1.
- **Out of range.**
  - Read 0x1bfffffc. Required: rdata=0x02800000, `access_err`=1.
  - Then read 0x1c000000. Required: data is correct and `access_err` stays 1.
- **Collision.** Same cycle: `ld_en` with index 2 and data 0xdeadbeef, plus a front read of 0x1c000008. Required: rdata=0x33333333 without the macro, 0xdeadbeef with `INST_SRAM_BYPASS_EN`. A follow-up read returns 0xdeadbeef in both builds.
- **Reset mid-operation.** Assert `reset` asynchronously mid-cycle during a read burst. Required: rdata, counters and err go to 0 immediately. After deassertion, word 0 still reads 0x11bb11dd.

Source files
------------

// File: rtl/inst_sram_resp_if.sv
// Fetch-side instruction SRAM port plus backdoor load and status signals.
interface inst_sram_resp_if #(
  parameter int unsigned DEPTH_LOG2 = 16
);
  logic                  inst_sram_en;
  logic [3:0]            inst_sram_we;
  logic [31:0]           inst_sram_addr;
  logic [31:0]           inst_sram_wdata;
  logic [31:0]           inst_sram_rdata;
  logic                  ld_en;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [31:0]           ld_data;
  logic                  access_err;
  logic [31:0]           rd_cnt;
  logic [31:0]           wr_cnt;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output ld_en, ld_addr, ld_data,
    input  inst_sram_rdata, access_err, rd_cnt, wr_cnt
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  ld_en, ld_addr, ld_data,
    output inst_sram_rdata, access_err, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: 1-cycle registered reads, byte writes, backdoor load, stats.
// Optional macro INST_SRAM_BYPASS_EN returns the post-write word on same-index collisions.
module inst_sram_resp #(
  parameter logic [31:0] ADDR_BASE  = 32'h1c000000,
  parameter int unsigned DEPTH_LOG2 = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_sram_resp_if.slave      bus_io
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
  localparam logic [31:0] NOP   = 32'h02800000;

  logic [31:0] mem [DEPTH];

  logic [31:0]           off_c;
  logic                  in_range_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic [31:0]           old_word_c;
  logic [31:0]           merged_word_c;
  logic [31:0]           resp_word_c;
  logic                  front_wr_c;
  logic                  ld_hit_c;
  logic                  mem_wr_c;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Address decode; wrap-around of the subtraction is caught by the base compare.
  assign off_c      = bus_io.inst_sram_addr - ADDR_BASE;
  assign in_range_c = (bus_io.inst_sram_addr >= ADDR_BASE) && ({1'b0, off_c} < SPAN);
  assign idx_c      = off_c[DEPTH_LOG2+1:2];
  assign old_word_c = mem[idx_c];
  assign front_wr_c = bus_io.inst_sram_en && (bus_io.inst_sram_we != 4'h0);
  assign ld_hit_c   = bus_io.ld_en && (bus_io.ld_addr == idx_c);
  assign mem_wr_c   = front_wr_c && in_range_c && !ld_hit_c && !reset;

  always_comb begin
    merged_word_c = old_word_c;
    for (int i = 0; i < 4; i++) begin
      if (bus_io.inst_sram_we[i]) merged_word_c[8*i +: 8] = bus_io.inst_sram_wdata[8*i +: 8];
    end
  end

`ifdef INST_SRAM_BYPASS_EN
  always_comb begin
    resp_word_c = old_word_c;
    if (ld_hit_c)        resp_word_c = bus_io.ld_data;
    else if (front_wr_c) resp_word_c = merged_word_c;
  end
`else
  assign resp_word_c = old_word_c;
`endif

  // Array is never reset; backdoor has priority on a shared index.
  always_ff @(posedge clk) begin
    if (mem_wr_c)     mem[idx_c] <= merged_word_c;
    if (bus_io.ld_en) mem[bus_io.ld_addr] <= bus_io.ld_data;
  end

  always_comb begin
    rdata_d  = rdata_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (bus_io.inst_sram_en) begin
      rdata_d = in_range_c ? resp_word_c : NOP;
      if (!in_range_c) err_d = 1'b1;
      if (front_wr_c) wr_cnt_d = wr_cnt_q + 32'd1;
      else            rd_cnt_d = rd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus_io.inst_sram_rdata = rdata_q;
  assign bus_io.access_err      = err_q;
  assign bus_io.rd_cnt          = rd_cnt_q;
  assign bus_io.wr_cnt          = wr_cnt_q;
endmodule
